inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch unit with a direct-mapped instruction cache. It sits between the memory controller and the decoder and is the requester on the controller's instruction port: it raises the instruction request, holds the address, and consumes the returned 32-bit word. It tracks the PC, serves hits in one cycle, refills misses through the memory controller, and handles branch redirects from the ROB/ALU.

## Interface
- ICACHE_LINES, 32: number of one-word cache lines, power of two; IDX_W = log2(ICACHE_LINES), TAG_W = 30 - IDX_W.
- RESET_PC, 32'h0: PC loaded on reset.

- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- rdy  in  1  ready; when low, all state and outputs are frozen.
- mc_req  out  1  instruction request to the memory controller (its inst_in_flg).
- mc_addr  out  32  word address of the request (its inst_addr), low two bits 0.
- mc_done  in  1  one-cycle completion pulse from the memory controller (its ret_inst_in_flg).
- mc_data  in  32  returned instruction word, valid only while mc_done=1 (its ret_res).
- stall  in  1  decoder cannot accept an instruction this cycle.
- jump_flg  in  1  redirect request, one cycle.
- jump_pc  in  32  redirect target, word aligned.
- out_valid  out  1  one-cycle pulse: out_inst/out_pc carry a new instruction.
- out_inst  out  32  fetched instruction.
- out_pc  out  32  address of out_inst.

## Operation
- Cache line = {valid, tag[TAG_W], data[32]}; index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]. Hit = valid && tag match.
- States: IDLE, WAIT, DISCARD.
- IDLE, stall=0, jump_flg=0: look up pc. Hit: out_valid=1, out_inst=line data, out_pc=pc, pc<=pc+4. Miss: mc_req<=1, mc_addr<=pc, state<=WAIT, out_valid=0.
- IDLE, stall=1: no lookup, out_valid=0, pc held.
- WAIT: mc_req and mc_addr held constant until mc_done. On mc_done: write line (valid=1, tag, mc_data) at mc_addr's index, mc_req<=0, state<=IDLE. No direct bypass to the output; the next IDLE lookup hits.
- Redirect (jump_flg=1) has priority over everything except rst and rdy=0. pc<=jump_pc and out_valid=0 that cycle, regardless of stall.
  - In IDLE: stay IDLE.
  - In WAIT without mc_done: the memory transaction cannot be cancelled. State<=DISCARD, mc_req and mc_addr held.
  - In WAIT with mc_done the same cycle: fill the line, state<=IDLE, pc<=jump_pc.
- DISCARD: same as WAIT, but on mc_done it fills the line (the data is correct for mc_addr) and returns to IDLE at the redirected pc. A further jump_flg in DISCARD only overwrites pc.
- PC arithmetic is 32-bit wrap-around: 32'hFFFF_FFFC + 4 = 0.
- The cache is never invalidated except by reset; there is no self-modifying-code support.

## Timing
- Reset (rst=1 at posedge): pc=RESET_PC, all valid bits=0, state=IDLE, mc_req=0, mc_addr=0, out_valid=0, out_inst=0, out_pc=0. Reset mid-WAIT abandons the transaction; the memory controller shares rst.
- All outputs are registered.
- Hit latency: out_valid is asserted in the cycle after the lookup edge; sustained throughput is one instruction per cycle while hitting and stall=0.
- Miss latency: mc_req is high the cycle after the miss. After the mc_done cycle there is one IDLE lookup cycle, then out_valid, giving controller latency + 2 cycles.
- mc_req is high only in WAIT or DISCARD, and drops the cycle after mc_done. The fetcher issues at most one outstanding request and never starts a new one in the cycle mc_done is seen.
- rdy=0: no state changes, including pc, cache, and mc_req. An mc_done seen while rdy=0 is ignored; the controller is frozen by the same rdy.

## Test plan
- Reset, then miss at PC 0: mc_req=1 with mc_addr=0. Return mc_done with 32'h00000013 after 4 cycles, then out_valid=1 with out_inst=32'h00000013, out_pc=0, two cycles after mc_done. mc_req is low the cycle after mc_done.
- Loop at 0x0–0xC, second pass: four consecutive out_valid pulses, pc 0/4/8/C, with mc_req staying 0.
- stall=1 for 3 cycles mid-hit-stream: out_valid=0 and pc held; the stream resumes at the next pc with no skipped or duplicated instruction.
- jump_flg with jump_pc=0x100 while in WAIT for 0x40: mc_addr stays 0x40 until mc_done and line 0x40 is filled. The next request is mc_addr=0x100, and no instruction from 0x40 is output.
- Aliasing with ICACHE_LINES=32: fetch 0x0, then 0x80 (same index). The second fetch misses and evicts, and a refetch of 0x0 misses again.
- rdy=0 for 5 cycles during WAIT with mc_done pulsed while rdy=0: no fill and no state change. Completion is accepted only when it is presented with rdy=1.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Instruction port between the fetch unit (requester) and the memory controller.
interface inst_fetch_if;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_done;
  logic [31:0] mc_data;

  modport master (
    output mc_req,
    output mc_addr,
    input  mc_done,
    input  mc_data
  );

  modport slave (
    input  mc_req,
    input  mc_addr,
    output mc_done,
    output mc_data
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch with a direct-mapped one-word-per-line cache, refilling misses through
// the memory controller and redirecting on jumps without cancelling in-flight refills.
module inst_fetch #(
  parameter int unsigned ICACHE_LINES = 32,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  inst_fetch_if.master        mc,
  input  logic                stall,
  input  logic                jump_flg,
  input  logic [31:0]         jump_pc,
  output logic                out_valid,
  output logic [31:0]         out_inst,
  output logic [31:0]         out_pc
);
  localparam int unsigned IdxW = $clog2(ICACHE_LINES);
  localparam int unsigned TagW = 30 - IdxW;

  typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        mc_req_q, mc_req_d;
  logic [31:0] mc_addr_q, mc_addr_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic [31:0] out_pc_q, out_pc_d;

  logic [ICACHE_LINES-1:0] valid_q;
  logic [TagW-1:0]         tag_q  [ICACHE_LINES];
  logic [31:0]             data_q [ICACHE_LINES];

  logic [IdxW-1:0] pc_idx, fill_idx;
  logic [TagW-1:0] pc_tag, fill_tag;
  logic            hit, fill_en;

  assign pc_idx   = pc_q[IdxW+1:2];
  assign pc_tag   = pc_q[31:IdxW+2];
  assign fill_idx = mc_addr_q[IdxW+1:2];
  assign fill_tag = mc_addr_q[31:IdxW+2];
  assign hit      = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mc_req_d    = mc_req_q;
    mc_addr_d   = mc_addr_q;
    out_valid_d = 1'b0;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    fill_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (jump_flg) begin
          pc_d = jump_pc;
        end else if (!stall) begin
          if (hit) begin
            out_valid_d = 1'b1;
            out_inst_d  = data_q[pc_idx];
            out_pc_d    = pc_q;
            pc_d        = pc_q + 32'd4;
          end else begin
            mc_req_d  = 1'b1;
            mc_addr_d = pc_q;
            state_d   = StWait;
          end
        end
      end
      StWait, StDiscard: begin
        // The refill is always written back, even after a redirect: the data is valid for
        // mc_addr regardless of where the PC now points.
        if (mc.mc_done) begin
          fill_en  = 1'b1;
          mc_req_d = 1'b0;
          state_d  = StIdle;
        end else if (jump_flg) begin
          state_d = StDiscard;
        end
        if (jump_flg) begin
          pc_d = jump_pc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      mc_req_q    <= 1'b0;
      mc_addr_q   <= 32'h0;
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'h0;
      out_pc_q    <= 32'h0;
      valid_q     <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mc_req_q    <= mc_req_d;
      mc_addr_q   <= mc_addr_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      if (fill_en) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag/data storage needs no reset; a line is only read once its valid bit is set.
  always_ff @(posedge clk) begin
    if (!rst && rdy && fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mc.mc_data;
    end
  end

  assign mc.mc_req  = mc_req_q;
  assign mc.mc_addr = mc_addr_q;
  assign out_valid  = out_valid_q;
  assign out_inst   = out_inst_q;
  assign out_pc     = out_pc_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized run checked
// against an architectural PC/program-order model and a latency-randomized memory model.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst, rdy, stall, jump_flg;
  logic [31:0] jump_pc;
  logic        out_valid;
  logic [31:0] out_inst, out_pc;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  inst_fetch_if mc_bus ();

  inst_fetch #(
    .ICACHE_LINES(32),
    .RESET_PC    (32'h0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .mc       (mc_bus),
    .stall    (stall),
    .jump_flg (jump_flg),
    .jump_pc  (jump_pc),
    .out_valid(out_valid),
    .out_inst (out_inst),
    .out_pc   (out_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Program memory contents: any address-dependent pattern, with word 0 = 32'h13.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h0101_0101) ^ 32'h0000_0013;
  endfunction

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_jump(input logic [31:0] tgt);
    jump_flg = 1'b1;
    jump_pc  = tgt;
    cyc();
    jump_flg = 1'b0;
  endtask

  // Waits (bounded) for a request, then answers it after lat cycles.
  task automatic serve(input int lat, output logic [31:0] a, output bit got);
    a = 32'h0;
    repeat (20) begin
      if (mc_bus.mc_req === 1'b1) break;
      cyc();
    end
    got = (mc_bus.mc_req === 1'b1);
    if (!got) return;
    a = mc_bus.mc_addr;
    repeat (lat) cyc();
    mc_bus.mc_done = 1'b1;
    mc_bus.mc_data = mem(a);
    cyc();
    mc_bus.mc_done = 1'b0;
    mc_bus.mc_data = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; stall = 1'b0; jump_flg = 1'b0; jump_pc = 32'h0;
    mc_bus.mc_done = 1'b0; mc_bus.mc_data = $urandom;
    cyc();
    cyc();
    total_cnt++;
    if (out_valid !== 1'b0 || mc_bus.mc_req !== 1'b0 || mc_bus.mc_addr !== 32'h0 ||
        out_inst !== 32'h0 || out_pc !== 32'h0)
      $display("FAIL reset_outputs got v=%b req=%b addr=%h inst=%h pc=%h required all zero",
               out_valid, mc_bus.mc_req, mc_bus.mc_addr, out_inst, out_pc);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_miss_at_zero();
    cyc();
    total_cnt++;
    if (mc_bus.mc_req !== 1'b1 || mc_bus.mc_addr !== 32'h0 || out_valid !== 1'b0)
      $display("FAIL miss0_req got req=%b addr=%h v=%b required req=1 addr=0 v=0",
               mc_bus.mc_req, mc_bus.mc_addr, out_valid);
    else pass_cnt++;
    repeat (3) cyc();
    total_cnt++;
    if (mc_bus.mc_req !== 1'b1 || mc_bus.mc_addr !== 32'h0)
      $display("FAIL miss0_hold got req=%b addr=%h required req=1 addr=0",
               mc_bus.mc_req, mc_bus.mc_addr);
    else pass_cnt++;
    mc_bus.mc_done = 1'b1;
    mc_bus.mc_data = 32'h0000_0013;
    cyc();
    mc_bus.mc_done = 1'b0;
    mc_bus.mc_data = $urandom;
    total_cnt++;
    if (mc_bus.mc_req !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL miss0_drop got req=%b v=%b required req=0 v=0", mc_bus.mc_req, out_valid);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (out_valid !== 1'b1 || out_inst !== 32'h13 || out_pc !== 32'h0)
      $display("FAIL miss0_out got v=%b inst=%h pc=%h required v=1 inst=00000013 pc=0",
               out_valid, out_inst, out_pc);
    else pass_cnt++;
  endtask

  task automatic test_loop_hits();
    logic [31:0] ga;
    bit          got;
    for (int i = 1; i < 4; i++) begin
      serve(1, ga, got);
      total_cnt++;
      if (!got || ga !== 32'(i * 4))
        $display("FAIL fill_req got=%b addr=%h required addr=%h", got, ga, 32'(i * 4));
      else pass_cnt++;
      cyc();
      total_cnt++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_inst !== mem(32'(i * 4)))
        $display("FAIL fill_out got v=%b pc=%h inst=%h required pc=%h inst=%h",
                 out_valid, out_pc, out_inst, 32'(i * 4), mem(32'(i * 4)));
      else pass_cnt++;
    end
    do_jump(32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      total_cnt++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_inst !== mem(32'(i * 4)) ||
          mc_bus.mc_req !== 1'b0)
        $display("FAIL loop_hit got v=%b pc=%h inst=%h req=%b required v=1 pc=%h req=0",
                 out_valid, out_pc, out_inst, mc_bus.mc_req, 32'(i * 4));
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    do_jump(32'h0);
    cyc();
    total_cnt++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0)
      $display("FAIL stall_pre got v=%b pc=%h required v=1 pc=0", out_valid, out_pc);
    else pass_cnt++;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total_cnt++;
      if (out_valid !== 1'b0)
        $display("FAIL stall_hold got v=%b required v=0", out_valid);
      else pass_cnt++;
    end
    stall = 1'b0;
    for (int i = 1; i < 3; i++) begin
      cyc();
      total_cnt++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_inst !== mem(32'(i * 4)))
        $display("FAIL stall_resume got v=%b pc=%h required v=1 pc=%h",
                 out_valid, out_pc, 32'(i * 4));
      else pass_cnt++;
    end
  endtask

  task automatic test_jump_in_wait();
    logic [31:0] ga;
    bit          got;
    do_jump(32'h40);
    cyc();
    total_cnt++;
    if (mc_bus.mc_req !== 1'b1 || mc_bus.mc_addr !== 32'h40)
      $display("FAIL jw_req got req=%b addr=%h required req=1 addr=40",
               mc_bus.mc_req, mc_bus.mc_addr);
    else pass_cnt++;
    do_jump(32'h100);
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if (mc_bus.mc_req !== 1'b1 || mc_bus.mc_addr !== 32'h40 || out_valid !== 1'b0)
        $display("FAIL jw_hold got req=%b addr=%h v=%b required req=1 addr=40 v=0",
                 mc_bus.mc_req, mc_bus.mc_addr, out_valid);
      else pass_cnt++;
      cyc();
    end
    mc_bus.mc_done = 1'b1;
    mc_bus.mc_data = mem(32'h40);
    cyc();
    mc_bus.mc_done = 1'b0;
    mc_bus.mc_data = $urandom;
    total_cnt++;
    if (mc_bus.mc_req !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL jw_done got req=%b v=%b required req=0 v=0", mc_bus.mc_req, out_valid);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (mc_bus.mc_req !== 1'b1 || mc_bus.mc_addr !== 32'h100 || out_valid !== 1'b0)
      $display("FAIL jw_next got req=%b addr=%h v=%b required req=1 addr=100 v=0",
               mc_bus.mc_req, mc_bus.mc_addr, out_valid);
    else pass_cnt++;
    serve(2, ga, got);
    cyc();
    total_cnt++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_inst !== mem(32'h100))
      $display("FAIL jw_out got v=%b pc=%h inst=%h required v=1 pc=100 inst=%h",
               out_valid, out_pc, out_inst, mem(32'h100));
    else pass_cnt++;
    do_jump(32'h40);
    cyc();
    total_cnt++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_inst !== mem(32'h40) ||
        mc_bus.mc_req !== 1'b0)
      $display("FAIL jw_filled got v=%b pc=%h inst=%h req=%b required hit at 40",
               out_valid, out_pc, out_inst, mc_bus.mc_req);
    else pass_cnt++;
  endtask

  task automatic test_alias();
    logic [31:0] ga;
    bit          got;
    logic [31:0] seq [3] = '{32'h0, 32'h80, 32'h0};
    // Line 0 was evicted by 0x100, so every step of this sequence must miss.
    for (int i = 0; i < 3; i++) begin
      do_jump(seq[i]);
      cyc();
      total_cnt++;
      if (mc_bus.mc_req !== 1'b1 || mc_bus.mc_addr !== seq[i] || out_valid !== 1'b0)
        $display("FAIL alias_miss got req=%b addr=%h v=%b required req=1 addr=%h v=0",
                 mc_bus.mc_req, mc_bus.mc_addr, out_valid, seq[i]);
      else pass_cnt++;
      serve(1, ga, got);
      cyc();
      total_cnt++;
      if (out_valid !== 1'b1 || out_pc !== seq[i] || out_inst !== mem(seq[i]))
        $display("FAIL alias_out got v=%b pc=%h inst=%h required pc=%h inst=%h",
                 out_valid, out_pc, out_inst, seq[i], mem(seq[i]));
      else pass_cnt++;
    end
  endtask

  task automatic test_rdy_freeze();
    logic [31:0] ga;
    bit          got;
    do_jump(32'h200);
    cyc();
    total_cnt++;
    if (mc_bus.mc_req !== 1'b1 || mc_bus.mc_addr !== 32'h200)
      $display("FAIL rdy_req got req=%b addr=%h required req=1 addr=200",
               mc_bus.mc_req, mc_bus.mc_addr);
    else pass_cnt++;
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mc_bus.mc_done = (i == 2);
      mc_bus.mc_data = 32'hDEAD_BEEF;
      cyc();
      total_cnt++;
      if (mc_bus.mc_req !== 1'b1 || mc_bus.mc_addr !== 32'h200 || out_valid !== 1'b0)
        $display("FAIL rdy_frozen got req=%b addr=%h v=%b required req=1 addr=200 v=0",
                 mc_bus.mc_req, mc_bus.mc_addr, out_valid);
      else pass_cnt++;
    end
    mc_bus.mc_done = 1'b0;
    rdy = 1'b1;
    cyc();
    total_cnt++;
    if (mc_bus.mc_req !== 1'b1)
      $display("FAIL rdy_still_wait got req=%b required 1", mc_bus.mc_req);
    else pass_cnt++;
    serve(1, ga, got);
    cyc();
    total_cnt++;
    if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_inst !== mem(32'h200))
      $display("FAIL rdy_out got v=%b pc=%h inst=%h required v=1 pc=200 inst=%h",
               out_valid, out_pc, out_inst, mem(32'h200));
    else pass_cnt++;
  endtask

  // Random stalls, redirects (including near the top of the address space), rdy gaps and
  // memory latencies; every delivered instruction must follow architectural program order.
  task automatic test_random();
    bit          busy = 1'b0;
    int          cnt = 0;
    int          outs = 0;
    logic [31:0] maddr = 32'h0;
    logic [31:0] ref_pc = 32'h0;
    bit          p_rdy, p_stall, p_jump, p_done;
    logic [31:0] p_jpc;
    rdy = 1'b1; stall = 1'b0; jump_flg = 1'b1; jump_pc = 32'h0; mc_bus.mc_done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      p_rdy = rdy; p_stall = stall; p_jump = jump_flg; p_jpc = jump_pc;
      p_done = mc_bus.mc_done;
      cyc();
      if (p_rdy && p_done) begin
        busy = 1'b0;
        total_cnt++;
        if (mc_bus.mc_req !== 1'b0)
          $display("FAIL rnd_req_drop got req=%b required 0", mc_bus.mc_req);
        else pass_cnt++;
      end else if (busy) begin
        total_cnt++;
        if (mc_bus.mc_req !== 1'b1 || mc_bus.mc_addr !== maddr)
          $display("FAIL rnd_req_hold got req=%b addr=%h required req=1 addr=%h",
                   mc_bus.mc_req, mc_bus.mc_addr, maddr);
        else pass_cnt++;
      end else if (mc_bus.mc_req === 1'b1) begin
        busy  = 1'b1;
        maddr = mc_bus.mc_addr;
        cnt   = $urandom_range(0, 4);
      end
      if (p_rdy) begin
        if (p_jump || p_stall) begin
          total_cnt++;
          if (out_valid !== 1'b0)
            $display("FAIL rnd_no_out got v=%b required 0 (jump=%b stall=%b)",
                     out_valid, p_jump, p_stall);
          else pass_cnt++;
        end else if (out_valid === 1'b1) begin
          total_cnt++;
          if (out_pc !== ref_pc || out_inst !== mem(ref_pc))
            $display("FAIL rnd_out got pc=%h inst=%h required pc=%h inst=%h",
                     out_pc, out_inst, ref_pc, mem(ref_pc));
          else pass_cnt++;
          ref_pc = ref_pc + 32'd4;
          outs++;
        end
        if (p_jump) ref_pc = p_jpc;
      end
      rdy      = ($urandom_range(0, 9) != 0);
      stall    = ($urandom_range(0, 4) == 0);
      jump_flg = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 15) == 0) jump_pc = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
      else jump_pc = 32'($urandom_range(0, 63)) << 2;
      mc_bus.mc_done = 1'b0;
      mc_bus.mc_data = $urandom;
      if (busy && rdy) begin
        if (cnt == 0) begin
          mc_bus.mc_done = 1'b1;
          mc_bus.mc_data = mem(maddr);
        end else begin
          cnt--;
        end
      end
    end
    jump_flg = 1'b0;
    total_cnt++;
    if (outs < 150)
      $display("FAIL rnd_progress got %0d instructions required at least 150", outs);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_miss_at_zero();
    test_loop_hits();
    test_stall();
    test_jump_in_wait();
    test_alias();
    test_rdy_freeze();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
